// File: rtl/fclass_pkg.sv
// Shared constants and types for the FCLASS.S class-occurrence statistics block.
package fclass_pkg;

    localparam int NUM_CLASS = 10;
    localparam int NUM_ENTRY = 11;
    localparam int IDX_W     = 4;

    // Entry indices follow the RISC-V FCLASS.S bit positions; the extra entry counts malformed masks.
    localparam logic [IDX_W-1:0] CLS_NEG_INF  = 4'd0;
    localparam logic [IDX_W-1:0] CLS_NEG_NORM = 4'd1;
    localparam logic [IDX_W-1:0] CLS_NEG_SUB  = 4'd2;
    localparam logic [IDX_W-1:0] CLS_NEG_ZERO = 4'd3;
    localparam logic [IDX_W-1:0] CLS_POS_ZERO = 4'd4;
    localparam logic [IDX_W-1:0] CLS_POS_SUB  = 4'd5;
    localparam logic [IDX_W-1:0] CLS_POS_NORM = 4'd6;
    localparam logic [IDX_W-1:0] CLS_POS_INF  = 4'd7;
    localparam logic [IDX_W-1:0] CLS_SNAN     = 4'd8;
    localparam logic [IDX_W-1:0] CLS_QNAN     = 4'd9;
    localparam logic [IDX_W-1:0] CLS_ERR      = 4'd10;

    typedef enum logic {
        RUN,
        CLEAR
    } state_e;

endpackage

// File: rtl/fclass_onehot_enc.sv
// Combinational encoder: turns an FCLASS mask into a bit index plus an exactly-one-hot flag.
module fclass_onehot_enc
    import fclass_pkg::*;
(
    input  logic [NUM_CLASS-1:0] mask_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 onehot_o
);

    // The index is only meaningful when the mask is one-hot; the caller redirects otherwise.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign onehot_o = $onehot(mask_i);

endmodule

// File: rtl/fclass_stats.sv
// Per-class saturating occurrence counters for FCLASS.S results, with a registered read port.
// Optional sticky saturation flag sat_irq is built when FCLASS_STATS_SAT_IRQ_EN is defined.
module fclass_stats
    import fclass_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_CLASS-1:0] class_mask,
    input  logic                 clr,
    output logic                 busy,
    input  logic                 rd_req,
    input  logic [IDX_W-1:0]     rd_sel,
    output logic                 rd_valid,
    output logic [CNT_W-1:0]     rd_data
`ifdef FCLASS_STATS_SAT_IRQ_EN
    ,
    output logic                 sat_irq
`endif
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q [NUM_ENTRY];

    logic [IDX_W-1:0]   encIdx;
    logic               encOneHot;
    logic               accept;
    logic [IDX_W-1:0]   incIdx;
    logic [CNT_W-1:0]   curVal;
    logic [CNT_W-1:0]   incVal;

    logic               wrEn;
    logic [IDX_W-1:0]   wrIdx;
    logic [CNT_W-1:0]   wrData;

    logic               rdValid_q;
    logic [CNT_W-1:0]   rdData_q;

    fclass_onehot_enc u_enc (
        .mask_i   (class_mask),
        .idx_o    (encIdx),
        .onehot_o (encOneHot)
    );

    // A beat arriving together with clr is dropped so the sweep starts from a clean array.
    assign accept = (state_q == RUN) && in_valid && !clr;
    assign incIdx = encOneHot ? encIdx : CLS_ERR;
    assign curVal = cnt_q[incIdx];
    assign incVal = (&curVal) ? curVal : curVal + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == CLS_ERR) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN);
        busy     = (state_q == CLEAR);
    end

    // Single write port keeps the array mappable onto a simple RAM.
    always_comb begin
        wrEn   = 1'b0;
        wrIdx  = idx_q;
        wrData = '0;
        if (state_q == CLEAR) begin
            wrEn = 1'b1;
        end else if (accept) begin
            wrEn   = 1'b1;
            wrIdx  = incIdx;
            wrData = incVal;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn && !rst) begin
            cnt_q[wrIdx] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            rdValid_q <= rd_req;
            if (rd_req) begin
                rdData_q <= (rd_sel < IDX_W'(NUM_ENTRY)) ? cnt_q[rd_sel] : '0;
            end
        end
    end

    assign rd_valid = rdValid_q;
    assign rd_data  = rdData_q;

`ifdef FCLASS_STATS_SAT_IRQ_EN
    logic satIrq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            satIrq_q <= 1'b0;
        end else if ((state_q == RUN) && clr) begin
            satIrq_q <= 1'b0;
        end else if (accept && (&incVal)) begin
            satIrq_q <= 1'b1;
        end
    end

    assign sat_irq = satIrq_q;
`endif

endmodule
